// File: rtl/qbert_pkg.sv
// Shared Q*bert renderer types: the cube sequencer state encoding and the default sizes.
package qbert_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    JUMP  = 2'd1,
    LAND  = 2'd2,
    CLEAR = 2'd3
  } cube_seq_state_t;

  localparam int N_CUBE_DEFAULT = 28;
  localparam int LEVEL_W        = 4;

endpackage

// File: rtl/cube_popcount.sv
// Combinational population count of an N_cube-wide cube mask.
module cube_popcount #(
  parameter int N_cube = 28
) (
  input  logic [N_cube-1:0]             mask,
  output logic [$clog2(N_cube+1)-1:0]   count
);

  localparam int CNT_W = $clog2(N_cube + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_cube; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/cube_color_sequencer.sv
// Pyramid colour sequencer: tracks jumps, commits landed cube colours, detects level completion.
// Optional build macro CUBE_REVERT_EN: landing on a coloured cube toggles it back.
module cube_color_sequencer
  import qbert_pkg::*;
#(
  parameter int N_cube = N_CUBE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_cube-1:0]             position_qb,
  input  logic [N_cube-1:0]             e_next_qb,
  input  logic                          done_move,
  input  logic                          level_ack,
  output logic [N_cube-1:0]             e_color_state,
  output logic [$clog2(N_cube+1)-1:0]   colored_cnt,
  output logic [LEVEL_W-1:0]            level,
  output logic                          busy,
  output logic                          land,
  output logic                          fall,
  output logic                          level_done,
  output cube_seq_state_t               state_dbg
);

  localparam int CNT_W = $clog2(N_cube + 1);

  cube_seq_state_t     state;
  logic [N_cube-1:0]   target;
  logic                armed;
  logic [N_cube-1:0]   color_upd;
  logic [CNT_W-1:0]    upd_cnt;

  always_comb begin
`ifdef CUBE_REVERT_EN
    color_upd = e_color_state ^ target;
`else
    color_upd = e_color_state | target;
`endif
  end

  cube_popcount #(.N_cube(N_cube)) u_popcount (
    .mask  (color_upd),
    .count (upd_cnt)
  );

  assign state_dbg = state;

  // Handshakes: done_move is a one-cycle pulse honoured only in JUMP from the cycle
  // after entry (armed); level_ack is honoured only in CLEAR; start overrides both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      target        <= '0;
      armed         <= 1'b0;
      e_color_state <= '0;
      colored_cnt   <= '0;
      level         <= '0;
      busy          <= 1'b0;
      land          <= 1'b0;
      fall          <= 1'b0;
      level_done    <= 1'b0;
    end else if (start) begin
      state         <= IDLE;
      target        <= '0;
      armed         <= 1'b0;
      e_color_state <= '0;
      colored_cnt   <= '0;
      busy          <= 1'b0;
      land          <= 1'b0;
      fall          <= 1'b0;
      level_done    <= 1'b0;
    end else begin
      land <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE: begin
          if (position_qb != e_next_qb) begin
            state  <= JUMP;
            target <= e_next_qb;
            armed  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        JUMP: begin
          armed <= 1'b1;
          if (armed && done_move) begin
            state <= LAND;
            busy  <= 1'b0;
            if (target == '0) fall <= 1'b1;
            else              land <= 1'b1;
          end
        end
        LAND: begin
          e_color_state <= color_upd;
          colored_cnt   <= upd_cnt;
          if (&color_upd) begin
            state      <= CLEAR;
            level_done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (level_ack) begin
            state         <= IDLE;
            level         <= level + LEVEL_W'(1);
            e_color_state <= '0;
            colored_cnt   <= '0;
            level_done    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
